// File: rtl/baud_rate_gen_core_if.sv
// Enable-pulse bundle between the baud generator and its UART consumers.
// The generator drives both strobes; receivers and transmitters only observe them.
interface baud_rate_gen_core_if;
    logic rxclk_en;
    logic txclk_en;

    modport master (
        output rxclk_en,
        output txclk_en
    );

    modport slave (
        input  rxclk_en,
        input  txclk_en
    );
endinterface

// File: rtl/baud_rate_gen_core.sv
// Baud generator: two free-running wrap counters decoded into 1-cycle rx/tx enable strobes.
// Strobes are combinational decodes of registered counts; no backpressure, counters never stall.
module baud_rate_gen_core #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clk_50m,
    input  logic                  rst,
    baud_rate_gen_core_if.master  bus
);
    localparam int RX_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int TX_DIV = CLK_FREQ / BAUD;
    // Width guards keep the declarations legal long enough for the divisor check to fire.
    localparam int RX_W   = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;
    localparam int TX_W   = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
    localparam logic [RX_W-1:0] RX_LAST = RX_W'(RX_DIV - 1);
    localparam logic [TX_W-1:0] TX_LAST = TX_W'(TX_DIV - 1);

    generate
        if (RX_DIV < 2 || TX_DIV < 2) begin : g_bad_div
            $fatal(1, "baud_rate_gen_core: divisor below 2 (RX_DIV=%0d TX_DIV=%0d)", RX_DIV, TX_DIV);
        end
    endgenerate

    logic [RX_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [TX_W-1:0] tx_cnt_q, tx_cnt_d;

    always_comb begin
        rx_cnt_d = rx_cnt_q + 1'b1;
        tx_cnt_d = tx_cnt_q + 1'b1;
        if (rx_cnt_q == RX_LAST) begin
            rx_cnt_d = '0;
        end
        if (tx_cnt_q == TX_LAST) begin
            tx_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            rx_cnt_q <= '0;
            tx_cnt_q <= '0;
        end else begin
            rx_cnt_q <= rx_cnt_d;
            tx_cnt_q <= tx_cnt_d;
        end
    end

    assign bus.rxclk_en = (rx_cnt_q == RX_LAST);
    assign bus.txclk_en = (tx_cnt_q == TX_LAST);
endmodule

// File: tb/tb_baud_rate_gen_core.sv
// Bench for baud_rate_gen_core: default and 1 MHz/9600 instances share clock and reset;
// every cycle is compared with pulse positions derived from edge counts since reset release.
module tb_baud_rate_gen_core;
    // Divisors as stated for each parameter set (50 MHz/115200/16 and 1 MHz/9600/16).
    localparam int RXD1 = 27;
    localparam int TXD1 = 434;
    localparam int RXD2 = 6;
    localparam int TXD2 = 104;

    logic clk_50m = 1'b0;
    logic rst     = 1'b1;

    int tests = 0;
    int fails = 0;
    int n     = 0;
    int rxp   = 0;
    int txp   = 0;

    baud_rate_gen_core_if if1 ();
    baud_rate_gen_core_if if2 ();

    baud_rate_gen_core u_dut1 (
        .clk_50m (clk_50m),
        .rst     (rst),
        .bus     (if1)
    );

    baud_rate_gen_core #(
        .CLK_FREQ   (1_000_000),
        .BAUD       (9600),
        .OVERSAMPLE (16)
    ) u_dut2 (
        .clk_50m (clk_50m),
        .rst     (rst),
        .bus     (if2)
    );

    always #5 clk_50m = ~clk_50m;

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at edge %0d: observed %b expected %b", tag, n, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // A pulse is due in the cycle following edge k*DIV-1 after reset release.
    function automatic logic due(input int edges, input int div);
        return (edges % div) == (div - 1);
    endfunction

    task automatic step();
        @(posedge clk_50m);
        n++;
        @(negedge clk_50m);
        chk("rx1", if1.rxclk_en, due(n, RXD1));
        chk("tx1", if1.txclk_en, due(n, TXD1));
        chk("rx2", if2.rxclk_en, due(n, RXD2));
        chk("tx2", if2.txclk_en, due(n, TXD2));
        if (if1.rxclk_en === 1'b1) rxp++;
        if (if1.txclk_en === 1'b1) txp++;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    // Called at a negedge; asserts reset between edges and checks the strobes drop without a clock.
    task automatic async_reset(input int hold);
        #($urandom_range(1, 3));
        rst = 1'b1;
        #1;
        chk("async_rx1", if1.rxclk_en, 1'b0);
        chk("async_tx1", if1.txclk_en, 1'b0);
        chk("async_rx2", if2.rxclk_en, 1'b0);
        chk("async_tx2", if2.txclk_en, 1'b0);
        n   = 0;
        rxp = 0;
        txp = 0;
        repeat (hold) @(posedge clk_50m);
        @(negedge clk_50m);
        chk("held_rx1", if1.rxclk_en, 1'b0);
        chk("held_tx1", if1.txclk_en, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk_50m);
        @(negedge clk_50m);
        chk("rst_rx1", if1.rxclk_en, 1'b0);
        chk("rst_tx1", if1.txclk_en, 1'b0);
        chk("rst_rx2", if2.rxclk_en, 1'b0);
        chk("rst_tx2", if2.txclk_en, 1'b0);
        rst = 1'b0;

        // 1000 and 2000 clocks from release: pulse totals.
        run(1000);
        chk_int("rx_pulses_1000", rxp, 37);
        chk_int("tx_pulses_1000", txp, 2);
        run(1000);
        chk_int("rx_pulses_2000", rxp, 74);
        chk_int("tx_pulses_2000", txp, 4);

        // Reset mid-count at rx count 10, then first pulse 26 edges later.
        async_reset(2);
        run(10);
        async_reset(1);
        run(30);
        chk_int("rx_first_after_rst", rxp, 1);

        // Reset while each strobe is high.
        async_reset(1);
        run(26);
        chk("rx_high_before_rst", if1.rxclk_en, 1'b1);
        async_reset(2);
        run(433);
        chk("tx_high_before_rst", if1.txclk_en, 1'b1);
        async_reset(3);

        // Random run lengths and reset points.
        for (int k = 0; k < 8; k++) begin
            run($urandom_range(1, 1500));
            async_reset($urandom_range(1, 4));
        end

        // Common multiple of both default divisors: strobes coincide, periods unchanged after.
        run(11717);
        chk("coincide_rx1", if1.rxclk_en, 1'b1);
        chk("coincide_tx1", if1.txclk_en, 1'b1);
        chk_int("rx_pulses_lcm", rxp, 434);
        chk_int("tx_pulses_lcm", txp, 27);
        run(500);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
